frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Top-level scheduler for the single frame buffer.
- Decodes host command bytes arriving from the SPI slave receive path and grants the buffer to either the pixel writer (capture) or the frame readout path (SPI transmit), never both.
- Latches the writer's final address as the frame length, tells the SPI transmit controller when to start, and reports a status byte.

Parameters:
- ADDR_W, 16, width of buffer address / frame length.
- TIMEOUT_CYCLES, 24'd10_000_000, max clk cycles allowed in CAPTURE before abort.
- RST_CYCLES, 4, cycles reader_reset is held low before a readout starts.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  host command byte from SPI slave.
- rx_valid  in  1  one-cycle pulse: rx_data valid.
- cam_vsync  in  1  camera frame-start signal, synchronous to clk.
- writer_done  in  1  pulse: writer stored end-of-frame.
- writer_overflow  in  1  pulse: writer reached end of buffer.
- writer_stop_addr  in  ADDR_W  last address written; valid with writer_done.
- tx_done  in  1  pulse: SPI transmit controller finished frame.
- writer_start  out  1  one-cycle pulse: writer begins at address 0.
- writer_abort  out  1  one-cycle pulse: writer stops immediately.
- reader_reset  out  1  active-low reset to pixel reader.
- tx_start  out  1  one-cycle pulse: start size+data transmission.
- buf_owner  out  2  00 none, 01 writer, 10 reader.
- frame_len  out  ADDR_W  latched stop address.
- frame_valid  out  1  buffer holds a complete frame.
- status  out  8  {frame_valid, state[2:0], err[3:0]}.

Behaviour:
- Reset values:
  - Outputs: all 0 except reader_reset=1.
  - Internal: state=IDLE, err=0, timeout counter 0.
  - Async reset mid-operation returns everything to these values immediately.
- Commands (acted on the cycle rx_valid=1; registered outputs change the next edge):
  - 0x01 CAPTURE, 0x02 READ, 0x03 ABORT.
  - Any other byte sets err=1 (UNKNOWN); state unchanged.
- State encodings: IDLE=0, ARM=1, CAPTURE=2, READY=3, RD_RST=4, READOUT=5.
- IDLE:
  - CAPTURE → ARM, err cleared.
  - READ → err=2 (NO_FRAME), stay IDLE.
- ARM:
  - cam_vsync rising edge is detected via a registered previous value.
  - On that edge: one-cycle writer_start pulse, buf_owner=01, timeout counter cleared, → CAPTURE.
  - READ → err=3 (BUSY).
- CAPTURE:
  - Counter increments every cycle.
  - writer_done → frame_len<=writer_stop_addr, frame_valid=1, buf_owner=00, → READY.
  - writer_overflow → err=4 (OVF), writer_abort pulse, frame_valid=0, buf_owner=00, → IDLE.
  - Counter reaches TIMEOUT_CYCLES-1 without done → err=5 (TIMEOUT), writer_abort pulse, frame_valid=0, buf_owner=00, → IDLE.
  - CAPTURE/READ commands → err=3.
- READY:
  - READ → err cleared, buf_owner=10, reader_reset=0, → RD_RST.
  - CAPTURE → frame_valid=0, err cleared, → ARM (frame overwrite).
- RD_RST:
  - reader_reset held low exactly RST_CYCLES cycles, then released.
  - On the release cycle: tx_start pulse, → READOUT.
- READOUT:
  - tx_done → buf_owner=00, → READY. Frame retained, so a re-read is permitted.
  - CAPTURE/READ → err=3.
- ABORT, any state:
  - → IDLE next cycle, frame_valid=0, buf_owner=00, err=0, reader_reset=1.
  - writer_abort pulses if the state was CAPTURE.
- Priority when events coincide in the same cycle:
  - ABORT > writer_done > writer_overflow > timeout.
  - ABORT > tx_done.
- buf_owner never changes directly 01↔10; it always passes through 00 for at least one cycle.
- Pulses on writer_done, writer_overflow, tx_done in states that don't expect them are ignored.
- err is sticky until cleared as stated above.

Test Plan:
- Reset, send 0x01, raise cam_vsync → writer_start one pulse one cycle after the edge, buf_owner=01, status[6:4]=2; writer_done with stop_addr=0x1234 → frame_len=0x1234, frame_valid=1, state=3.
- From READY send 0x02 → reader_reset low exactly 4 cycles, buf_owner=10, tx_start single pulse at release; tx_done → buf_owner=00, state=3. A second 0x02 repeats the sequence.
- Send 0x02 after reset → err=2, state stays 0; send 0x7F → err=1.
- TIMEOUT_CYCLES=100, capture with no writer_done → writer_abort at cycle 100 of CAPTURE, err=5, frame_valid=0, state=0.
- In CAPTURE, assert 0x03 and writer_done in the same cycle → IDLE, frame_valid=0, writer_abort pulse, frame_len unchanged.
- During READOUT, drop reset mid-frame → all outputs at reset values asynchronously; after release, state=0 and frame_valid=0.

Source files
------------

// File: rtl/frame_sequencer.sv
// Frame buffer scheduler: decodes host command bytes and grants the single frame
// buffer to either the pixel writer (capture) or the SPI readout path.
module frame_sequencer #(
    parameter int          ADDR_W         = 16,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
    parameter int          RST_CYCLES     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              cam_vsync,
    input  logic              writer_done,
    input  logic              writer_overflow,
    input  logic [ADDR_W-1:0] writer_stop_addr,
    input  logic              tx_done,
    output logic              writer_start,
    output logic              writer_abort,
    output logic              reader_reset,
    output logic              tx_start,
    output logic [1:0]        buf_owner,
    output logic [ADDR_W-1:0] frame_len,
    output logic              frame_valid,
    output logic [7:0]        status
);

    // state   | meaning
    // IDLE    | no activity, buffer unowned
    // ARM     | capture requested, waiting for camera vsync rising edge
    // CAPTURE | writer owns buffer, timeout counter running
    // READY   | complete frame held, buffer unowned
    // RD_RST  | reader owns buffer, reader held in reset for RST_CYCLES
    // READOUT | SPI transmit in progress
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_CAPTURE = 3'd2,
        S_READY   = 3'd3,
        S_RD_RST  = 3'd4,
        S_READOUT = 3'd5
    } state_t;

    localparam logic [7:0] CMD_CAPTURE = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h02;
    localparam logic [7:0] CMD_ABORT   = 8'h03;

    localparam logic [3:0] ERR_NONE     = 4'd0;
    localparam logic [3:0] ERR_UNKNOWN  = 4'd1;
    localparam logic [3:0] ERR_NO_FRAME = 4'd2;
    localparam logic [3:0] ERR_BUSY     = 4'd3;
    localparam logic [3:0] ERR_OVF      = 4'd4;
    localparam logic [3:0] ERR_TIMEOUT  = 4'd5;

    localparam logic [1:0] OWN_NONE   = 2'b00;
    localparam logic [1:0] OWN_WRITER = 2'b01;
    localparam logic [1:0] OWN_READER = 2'b10;

    localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);

    state_t              state_q;
    logic [3:0]          err_q;
    logic [23:0]         tmo_cnt_q;
    logic [7:0]          rst_cnt_q;
    logic                vsync_q;
    logic                writer_start_q;
    logic                writer_abort_q;
    logic                reader_reset_q;
    logic                tx_start_q;
    logic [1:0]          buf_owner_q;
    logic [ADDR_W-1:0]   frame_len_q;
    logic                frame_valid_q;

    logic cmd_capture, cmd_read, cmd_abort, cmd_unknown, vsync_rise;

    assign cmd_capture = rx_valid && (rx_data == CMD_CAPTURE);
    assign cmd_read    = rx_valid && (rx_data == CMD_READ);
    assign cmd_abort   = rx_valid && (rx_data == CMD_ABORT);
    assign cmd_unknown = rx_valid && !cmd_capture && !cmd_read && !cmd_abort;
    assign vsync_rise  = cam_vsync && !vsync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            err_q          <= ERR_NONE;
            tmo_cnt_q      <= '0;
            rst_cnt_q      <= '0;
            vsync_q        <= 1'b0;
            writer_start_q <= 1'b0;
            writer_abort_q <= 1'b0;
            reader_reset_q <= 1'b1;
            tx_start_q     <= 1'b0;
            buf_owner_q    <= OWN_NONE;
            frame_len_q    <= '0;
            frame_valid_q  <= 1'b0;
        end else begin
            vsync_q        <= cam_vsync;
            writer_start_q <= 1'b0;
            writer_abort_q <= 1'b0;
            tx_start_q     <= 1'b0;
            if (cmd_abort) begin
                // Abort outranks every coinciding writer/transmit event
                writer_abort_q <= (state_q == S_CAPTURE);
                state_q        <= S_IDLE;
                frame_valid_q  <= 1'b0;
                buf_owner_q    <= OWN_NONE;
                err_q          <= ERR_NONE;
                reader_reset_q <= 1'b1;
            end else begin
                if (cmd_unknown)
                    err_q <= ERR_UNKNOWN;
                case (state_q)
                    S_IDLE: begin
                        if (cmd_capture) begin
                            err_q   <= ERR_NONE;
                            state_q <= S_ARM;
                        end else if (cmd_read) begin
                            err_q <= ERR_NO_FRAME;
                        end
                    end
                    S_ARM: begin
                        if (cmd_read)
                            err_q <= ERR_BUSY;
                        if (vsync_rise) begin
                            writer_start_q <= 1'b1;
                            buf_owner_q    <= OWN_WRITER;
                            tmo_cnt_q      <= '0;
                            state_q        <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        tmo_cnt_q <= tmo_cnt_q + 24'd1;
                        if (cmd_capture || cmd_read)
                            err_q <= ERR_BUSY;
                        if (writer_done) begin
                            frame_len_q   <= writer_stop_addr;
                            frame_valid_q <= 1'b1;
                            buf_owner_q   <= OWN_NONE;
                            state_q       <= S_READY;
                        end else if (writer_overflow) begin
                            err_q          <= ERR_OVF;
                            writer_abort_q <= 1'b1;
                            frame_valid_q  <= 1'b0;
                            buf_owner_q    <= OWN_NONE;
                            state_q        <= S_IDLE;
                        end else if (tmo_cnt_q == TIMEOUT_CYCLES - 24'd1) begin
                            err_q          <= ERR_TIMEOUT;
                            writer_abort_q <= 1'b1;
                            frame_valid_q  <= 1'b0;
                            buf_owner_q    <= OWN_NONE;
                            state_q        <= S_IDLE;
                        end
                    end
                    S_READY: begin
                        if (cmd_read) begin
                            err_q          <= ERR_NONE;
                            buf_owner_q    <= OWN_READER;
                            reader_reset_q <= 1'b0;
                            rst_cnt_q      <= RST_LOAD;
                            state_q        <= S_RD_RST;
                        end else if (cmd_capture) begin
                            frame_valid_q <= 1'b0;
                            err_q         <= ERR_NONE;
                            state_q       <= S_ARM;
                        end
                    end
                    S_RD_RST: begin
                        if (rst_cnt_q == 8'd0) begin
                            reader_reset_q <= 1'b1;
                            tx_start_q     <= 1'b1;
                            state_q        <= S_READOUT;
                        end else begin
                            rst_cnt_q <= rst_cnt_q - 8'd1;
                        end
                    end
                    S_READOUT: begin
                        if (cmd_capture || cmd_read)
                            err_q <= ERR_BUSY;
                        if (tx_done) begin
                            buf_owner_q <= OWN_NONE;
                            state_q     <= S_READY;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign writer_start = writer_start_q;
    assign writer_abort = writer_abort_q;
    assign reader_reset = reader_reset_q;
    assign tx_start     = tx_start_q;
    assign buf_owner    = buf_owner_q;
    assign frame_len    = frame_len_q;
    assign frame_valid  = frame_valid_q;
    assign status       = {frame_valid_q, state_q, err_q};

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: randomized command scenarios compared
// against an abstract model of expected state, error code, frame validity and length.
module tb_frame_sequencer;
    localparam int          AW = 16;
    localparam logic [23:0] TO = 24'd100;
    localparam int          RC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          writer_done = 1'b0;
    logic          writer_overflow = 1'b0;
    logic [AW-1:0] writer_stop_addr = '0;
    logic          tx_done = 1'b0;
    logic          writer_start, writer_abort, reader_reset, tx_start, frame_valid;
    logic [1:0]    buf_owner;
    logic [AW-1:0] frame_len;
    logic [7:0]    status;

    frame_sequencer #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO), .RST_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .cam_vsync(cam_vsync), .writer_done(writer_done), .writer_overflow(writer_overflow),
        .writer_stop_addr(writer_stop_addr), .tx_done(tx_done),
        .writer_start(writer_start), .writer_abort(writer_abort), .reader_reset(reader_reset),
        .tx_start(tx_start), .buf_owner(buf_owner), .frame_len(frame_len),
        .frame_valid(frame_valid), .status(status)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Abstract model: what the host should be able to see at any time
    logic [2:0]    exp_state = 3'd0;
    logic [3:0]    exp_err = 4'd0;
    logic          exp_fv = 1'b0;
    logic [AW-1:0] exp_len = '0;

    function automatic logic [7:0] exp_status();
        return {exp_fv, exp_state, exp_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({writer_start, writer_abort, reader_reset, tx_start, buf_owner, frame_valid} !== 7'b0010000) begin
            $display("FAIL reset_outputs got %b want %b",
                     {writer_start, writer_abort, reader_reset, tx_start, buf_owner, frame_valid}, 7'b0010000);
            n_bad++;
        end
        n_cmp++;
        if (status !== 8'h00 || frame_len !== '0) begin
            $display("FAIL reset_status got %h/%h want 00/0000", status, frame_len);
            n_bad++;
        end
    endtask

    task automatic test_errors();
        logic [7:0] junk;
        send_cmd(8'h02);
        exp_err = 4'd2;
        n_cmp++;
        if (status !== exp_status()) begin
            $display("FAIL read_no_frame status got %h want %h", status, exp_status());
            n_bad++;
        end
        junk = 8'($urandom_range(4, 255));
        send_cmd(junk);
        exp_err = 4'd1;
        n_cmp++;
        if (status !== exp_status()) begin
            $display("FAIL unknown_cmd %h status got %h want %h", junk, status, exp_status());
            n_bad++;
        end
    endtask

    task automatic start_capture();
        send_cmd(8'h01);
        exp_state = 3'd1;
        exp_err = 4'd0;
        exp_fv = 1'b0;
        n_cmp++;
        if (status !== exp_status()) begin
            $display("FAIL arm status got %h want %h", status, exp_status());
            n_bad++;
        end
        repeat ($urandom_range(0, 4)) tick();
        cam_vsync = 1'b1;
        tick();
        exp_state = 3'd2;
        n_cmp++;
        if (writer_start !== 1'b1 || buf_owner !== 2'b01 || status !== exp_status()) begin
            $display("FAIL capture_entry start/owner/status got %b/%b/%h want 1/01/%h",
                     writer_start, buf_owner, status, exp_status());
            n_bad++;
        end
        tick();
        cam_vsync = 1'b0;
        n_cmp++;
        if (writer_start !== 1'b0) begin
            $display("FAIL writer_start_width got %b want 0", writer_start);
            n_bad++;
        end
    endtask

    task automatic finish_capture(input logic [AW-1:0] addr);
        repeat ($urandom_range(1, 40)) tick();
        writer_stop_addr = addr;
        writer_done = 1'b1;
        tick();
        writer_done = 1'b0;
        exp_state = 3'd3;
        exp_fv = 1'b1;
        exp_len = addr;
        n_cmp++;
        if (frame_len !== exp_len || buf_owner !== 2'b00 || status !== exp_status()) begin
            $display("FAIL capture_done len/owner/status got %h/%b/%h want %h/00/%h",
                     frame_len, buf_owner, status, exp_len, exp_status());
            n_bad++;
        end
    endtask

    task automatic test_readout();
        int low;
        logic owner_bad;
        send_cmd(8'h02);
        exp_state = 3'd4;
        exp_err = 4'd0;
        n_cmp++;
        if (buf_owner !== 2'b10 || status !== exp_status()) begin
            $display("FAIL rd_rst_entry owner/status got %b/%h want 10/%h", buf_owner, status, exp_status());
            n_bad++;
        end
        low = 0;
        owner_bad = 1'b0;
        while (reader_reset === 1'b0 && low < 20) begin
            low++;
            if (buf_owner !== 2'b10 || tx_start !== 1'b0) owner_bad = 1'b1;
            tick();
        end
        exp_state = 3'd5;
        n_cmp++;
        if (low != RC || owner_bad || tx_start !== 1'b1 || status !== exp_status()) begin
            $display("FAIL reader_reset_low cycles/glitch/tx_start/status got %0d/%b/%b/%h want %0d/0/1/%h",
                     low, owner_bad, tx_start, status, RC, exp_status());
            n_bad++;
        end
        tick();
        n_cmp++;
        if (tx_start !== 1'b0 || buf_owner !== 2'b10) begin
            $display("FAIL tx_start_width start/owner got %b/%b want 0/10", tx_start, buf_owner);
            n_bad++;
        end
        send_cmd(8'h02);
        exp_err = 4'd3;
        n_cmp++;
        if (status !== exp_status()) begin
            $display("FAIL readout_busy status got %h want %h", status, exp_status());
            n_bad++;
        end
        repeat ($urandom_range(0, 6)) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        exp_state = 3'd3;
        n_cmp++;
        if (buf_owner !== 2'b00 || frame_len !== exp_len || status !== exp_status()) begin
            $display("FAIL tx_done owner/len/status got %b/%h/%h want 00/%h/%h",
                     buf_owner, frame_len, status, exp_len, exp_status());
            n_bad++;
        end
    endtask

    task automatic test_timeout();
        int c;
        start_capture();
        c = 1;
        while (writer_abort !== 1'b1 && c < 300) begin
            tick();
            c++;
        end
        exp_state = 3'd0;
        exp_err = 4'd5;
        exp_fv = 1'b0;
        n_cmp++;
        if (c != int'(TO) || status !== exp_status() || buf_owner !== 2'b00) begin
            $display("FAIL timeout cycles/status/owner got %0d/%h/%b want %0d/%h/00",
                     c, status, buf_owner, TO, exp_status());
            n_bad++;
        end
    endtask

    task automatic test_overflow();
        start_capture();
        repeat ($urandom_range(1, 30)) tick();
        writer_overflow = 1'b1;
        tick();
        writer_overflow = 1'b0;
        exp_state = 3'd0;
        exp_err = 4'd4;
        exp_fv = 1'b0;
        n_cmp++;
        if (writer_abort !== 1'b1 || buf_owner !== 2'b00 || frame_len !== exp_len || status !== exp_status()) begin
            $display("FAIL overflow abort/owner/len/status got %b/%b/%h/%h want 1/00/%h/%h",
                     writer_abort, buf_owner, frame_len, status, exp_len, exp_status());
            n_bad++;
        end
    endtask

    task automatic test_abort_vs_done();
        start_capture();
        repeat ($urandom_range(1, 30)) tick();
        writer_stop_addr = AW'($urandom);
        writer_done = 1'b1;
        rx_data = 8'h03;
        rx_valid = 1'b1;
        tick();
        writer_done = 1'b0;
        rx_valid = 1'b0;
        exp_state = 3'd0;
        exp_err = 4'd0;
        exp_fv = 1'b0;
        n_cmp++;
        if (writer_abort !== 1'b1 || frame_len !== exp_len || buf_owner !== 2'b00 || status !== exp_status()) begin
            $display("FAIL abort_vs_done abort/len/owner/status got %b/%h/%b/%h want 1/%h/00/%h",
                     writer_abort, frame_len, buf_owner, status, exp_len, exp_status());
            n_bad++;
        end
        tick();
        n_cmp++;
        if (writer_abort !== 1'b0) begin
            $display("FAIL abort_width got %b want 0", writer_abort);
            n_bad++;
        end
    endtask

    task automatic test_async_reset();
        start_capture();
        finish_capture(AW'($urandom));
        send_cmd(8'h02);
        repeat (RC + 2) tick();
        #2;
        reset = 1'b0;
        #1;
        exp_state = 3'd0;
        exp_err = 4'd0;
        exp_fv = 1'b0;
        exp_len = '0;
        n_cmp++;
        if (reader_reset !== 1'b1 || buf_owner !== 2'b00 || tx_start !== 1'b0 ||
            frame_len !== exp_len || status !== exp_status()) begin
            $display("FAIL async_reset rrst/owner/tx/len/status got %b/%b/%b/%h/%h want 1/00/0/%h/%h",
                     reader_reset, buf_owner, tx_start, frame_len, status, exp_len, exp_status());
            n_bad++;
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (status !== exp_status() || frame_valid !== 1'b0) begin
            $display("FAIL post_reset status/fv got %h/%b want %h/0", status, frame_valid, exp_status());
            n_bad++;
        end
    endtask

    initial begin
        repeat (3) tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_reset();
        test_errors();
        for (int i = 0; i < 3; i++) begin
            start_capture();
            finish_capture((i == 0) ? 16'h1234 : AW'($urandom));
            test_readout();
            test_readout();
        end
        test_timeout();
        test_overflow();
        start_capture();
        finish_capture(AW'($urandom));
        test_abort_vs_done();
        start_capture();
        finish_capture(AW'($urandom));
        start_capture();
        finish_capture(AW'($urandom));
        test_readout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
